// File: rtl/srt_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : srt_frame_tx
//  Description : Frame transmitter. On start it emits a three-beat header
//                (rows of a 3x4 coefficient matrix) followed by cfg_len
//                vector beats taken from an AXIS source. The output is a
//                single-register AXIS master, and m_tlast marks the final beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module srt_frame_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,   // only 4 lanes are supported
  parameter int LEN_WIDTH  = 16
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          start,
  input  logic [12*DATA_WIDTH-1:0]      cfg_mat,
  input  logic [LEN_WIDTH-1:0]          cfg_len,
  output logic                          busy,
  output logic                          done,
  input  logic [LANES*DATA_WIDTH-1:0]   v_tdata,
  input  logic                          v_tvalid,
  output logic                          v_tready,
  output logic [LANES*DATA_WIDTH-1:0]   m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast
);

  localparam int BEAT_W = LANES * DATA_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_VEC  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]              r_state;
  logic [1:0]              w_state_next;
  logic [12*DATA_WIDTH-1:0] r_mat;
  logic [LEN_WIDTH-1:0]    r_len;
  logic [1:0]              r_hidx;
  logic [LEN_WIDTH-1:0]    r_rem;
  logic [BEAT_W-1:0]       r_mdata;
  logic                    r_mvalid;
  logic                    r_mlast;

  logic                    w_m_hs;
  logic                    w_v_hs;
  logic                    w_hdr_last;
  logic                    w_vready_hdr;
  logic                    w_vready_vec;

  // The final header beat is being presented.
  assign w_hdr_last   = (r_state == S_HDR) && (r_hidx == 2'd2);
  // Vector 0 may be pulled in on the same edge that header beat 2 leaves,
  // so the frame has no bubble between header and payload.
  assign w_vready_hdr = w_hdr_last && (r_len != '0) && m_tready;
  assign w_vready_vec = (r_state == S_VEC) && (r_rem != '0) && (!r_mvalid || m_tready);
  assign w_m_hs       = r_mvalid && m_tready;
  assign w_v_hs       = v_tvalid && v_tready;

  assign m_tdata  = r_mdata;
  assign m_tvalid = r_mvalid;
  assign m_tlast  = r_mlast;

  // State register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: header beats, then vectors, then a one-cycle finish.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_next = S_HDR;
      S_HDR: begin
        if (w_hdr_last && w_m_hs) begin
          w_state_next = (r_len == '0) ? S_FIN : S_VEC;
        end
      end
      S_VEC: if (w_m_hs && r_mlast) w_state_next = S_FIN;
      S_FIN: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Status and source-ready outputs decoded from the state.
  always_comb begin
    busy     = (r_state != S_IDLE);
    done     = (r_state == S_FIN);
    v_tready = w_vready_hdr || w_vready_vec;
  end

  // Frame configuration is captured on an accepted start; no reset needed
  // because every frame reloads it.
  always_ff @(posedge aclk) begin
    if ((r_state == S_IDLE) && start) begin
      r_mat <= cfg_mat;
      r_len <= cfg_len;
    end
  end

  // Output register, header index and remaining-vector counter.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_mdata  <= '0;
      r_mvalid <= 1'b0;
      r_mlast  <= 1'b0;
      r_hidx   <= 2'd0;
      r_rem    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mdata  <= cfg_mat[0 +: BEAT_W];
            r_mvalid <= 1'b1;
            r_mlast  <= 1'b0;
            r_hidx   <= 2'd0;
          end
        end
        S_HDR: begin
          if (w_m_hs) begin
            case (r_hidx)
              2'd0: begin
                r_mdata <= r_mat[BEAT_W +: BEAT_W];
                r_hidx  <= 2'd1;
              end
              2'd1: begin
                r_mdata <= r_mat[2*BEAT_W +: BEAT_W];
                r_mlast <= (r_len == '0);
                r_hidx  <= 2'd2;
              end
              default: begin
                if (w_v_hs) begin
                  r_mdata  <= v_tdata;
                  r_mvalid <= 1'b1;
                  r_mlast  <= (r_len == LEN_WIDTH'(1));
                  r_rem    <= r_len - LEN_WIDTH'(1);
                end else begin
                  r_mvalid <= 1'b0;
                  r_mlast  <= 1'b0;
                  r_rem    <= r_len;
                end
              end
            endcase
          end
        end
        S_VEC: begin
          if (w_v_hs) begin
            r_mdata  <= v_tdata;
            r_mvalid <= 1'b1;
            r_mlast  <= (r_rem == LEN_WIDTH'(1));
            r_rem    <= r_rem - LEN_WIDTH'(1);
          end else if (w_m_hs) begin
            r_mvalid <= 1'b0;
            r_mlast  <= 1'b0;
          end
        end
        default: begin
          r_mvalid <= 1'b0;
          r_mlast  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_srt_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_srt_frame_tx
//  Description : Directed self-checking bench for srt_frame_tx.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_srt_frame_tx;
  localparam int DW = 16;
  localparam int LW = 4;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start = 1'b0;
  logic [191:0]  cfg_mat = '0;
  logic [LW-1:0] cfg_len = '0;
  logic          busy, done;
  logic [63:0]   v_tdata = '0;
  logic          v_tvalid = 1'b0;
  logic          v_tready;
  logic [63:0]   m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;

  srt_frame_tx #(.DATA_WIDTH(DW), .LANES(4), .LEN_WIDTH(LW)) u_dut (
    .aclk(aclk), .aresetn(aresetn), .start(start),
    .cfg_mat(cfg_mat), .cfg_len(cfg_len),
    .busy(busy), .done(done),
    .v_tdata(v_tdata), .v_tvalid(v_tvalid), .v_tready(v_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  logic [63:0] rx_d[$];
  bit          rx_l[$];
  int          rx_c[$];
  int          done_q[$];
  int          vr_cnt = 0;
  bit          stall_prev = 1'b0;
  logic [63:0] held_d;
  logic        held_l;
  bit          tr_mode = 1'b0;
  bit          src_abort = 1'b0;
  logic [63:0] vecs [0:31];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: records accepted beats, done pulses and holds during stalls.
  always @(negedge aclk) begin
    if (stall_prev && aresetn) begin
      chk("hold_valid", 64'(m_tvalid), 64'd1);
      chk("hold_data", m_tdata, held_d);
      chk("hold_last", 64'(m_tlast), 64'(held_l));
    end
    stall_prev = m_tvalid && !m_tready;
    held_d     = m_tdata;
    held_l     = m_tlast;
    if (m_tvalid && m_tready) begin
      rx_d.push_back(m_tdata);
      rx_l.push_back(m_tlast);
      rx_c.push_back(cyc);
    end
    if (done) done_q.push_back(cyc);
    if (v_tready) vr_cnt++;
  end

  // Output ready: always high, or toggling every cycle.
  initial begin
    forever begin
      @(posedge aclk); #1;
      if (tr_mode) m_tready = ~m_tready;
      else         m_tready = 1'b1;
    end
  end

  task automatic drive_src(input int n, input int starve_after);
    int i = 0;
    int gap = 0;
    int budget = 0;
    bit hs;
    while (i < n && !src_abort && budget < 400) begin
      budget++;
      if (i == starve_after && gap < 5) begin
        v_tvalid = 1'b0;
        gap++;
        @(posedge aclk); #1;
      end else begin
        v_tvalid = 1'b1;
        v_tdata  = vecs[i];
        @(negedge aclk);
        hs = v_tready;
        @(posedge aclk); #1;
        if (hs) i++;
      end
    end
    v_tvalid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (done_q.size() == 0 && t < 400) begin
      @(negedge aclk); #1;
      t++;
    end
    chk("done_seen", 64'(done_q.size() != 0), 64'd1);
  endtask

  task automatic clear_mon();
    rx_d.delete(); rx_l.delete(); rx_c.delete(); done_q.delete();
    vr_cnt = 0;
  endtask

  task automatic run_frame(input logic [191:0] mat, input int len, input int starve_after,
                           input bit start_busy, input bit idle_after, input bit consec);
    logic [63:0] exp_d[$];
    bit          exp_l[$];
    int          k;
    clear_mon();
    for (int h = 0; h < 3; h++) begin
      exp_d.push_back(mat[h*64 +: 64]);
      exp_l.push_back(len == 0 && h == 2);
    end
    for (int i = 0; i < len; i++) begin
      exp_d.push_back(vecs[i]);
      exp_l.push_back(i == len - 1);
    end
    fork drive_src(len, starve_after); join_none
    @(posedge aclk); #1;
    cfg_mat = mat; cfg_len = LW'(len); start = 1'b1; k = cyc;
    @(posedge aclk); #1;
    start = 1'b0; cfg_mat = ~mat; cfg_len = LW'(len + 3);
    chk("busy_on", 64'(busy), 64'd1);
    if (start_busy) begin
      start = 1'b1;
      @(posedge aclk); #1;
      start = 1'b0;
    end
    wait_done();
    if (idle_after) begin
      repeat (3) @(posedge aclk);
      #1;
      chk("done_once", 64'(done_q.size()), 64'd1);
      chk("busy_off", 64'(busy), 64'd0);
    end
    chk("nbeats", 64'(rx_d.size()), 64'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < rx_d.size(); i++) begin
      chk($sformatf("data%0d", i), rx_d[i], exp_d[i]);
      chk($sformatf("last%0d", i), 64'(rx_l[i]), 64'(exp_l[i]));
    end
    if (rx_c.size() > 0 && done_q.size() > 0)
      chk("done_lat", 64'(done_q[0]), 64'(rx_c[rx_c.size()-1] + 1));
    if (consec && rx_c.size() > 0) begin
      chk("lat_first", 64'(rx_c[0]), 64'(k + 1));
      for (int i = 1; i < rx_c.size(); i++)
        chk($sformatf("consec%0d", i), 64'(rx_c[i] - rx_c[0]), 64'(i));
    end
    if (starve_after >= 0 && rx_c.size() > 3 + starve_after)
      chk("starve_gap", 64'((rx_c[3+starve_after] - rx_c[2+starve_after]) >= 5), 64'd1);
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_tvalid"}, 64'(m_tvalid), 64'd0);
    chk({pfx, "_tlast"},  64'(m_tlast),  64'd0);
    chk({pfx, "_tdata"},  m_tdata,       64'd0);
    chk({pfx, "_vready"}, 64'(v_tready), 64'd0);
    chk({pfx, "_busy"},   64'(busy),     64'd0);
    chk({pfx, "_done"},   64'(done),     64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [191:0] mat_a, mat_b;
  int           n0, t;

  initial begin
    // elements 1..12, a00 in the LSBs
    mat_a = 192'h000c_000b_000a_0009_0008_0007_0006_0005_0004_0003_0002_0001;
    mat_b = 192'h1c1c_1b1b_1a1a_1919_1818_1717_1616_1515_1414_1313_1212_1111;

    // reset values
    repeat (3) @(posedge aclk);
    #1;
    check_zero("rst");
    aresetn = 1'b1;

    // basic frame
    vecs[0] = 64'hA; vecs[1] = 64'hB;
    run_frame(mat_a, 2, -1, 1'b0, 1'b1, 1'b1);
    chk("hdr0_const", rx_d.size() > 0 ? rx_d[0] : 64'hx, 64'h0004_0003_0002_0001);
    chk("hdr2_const", rx_d.size() > 2 ? rx_d[2] : 64'hx, 64'h000c_000b_000a_0009);

    // header-only frame
    run_frame(mat_b, 0, -1, 1'b0, 1'b1, 1'b1);
    chk("vready_never", 64'(vr_cnt), 64'd0);

    // backpressure, 3+4 beats
    for (int i = 0; i < 4; i++) vecs[i] = 64'h5500_0000_0000_0000 + 64'(i * 3 + 1);
    tr_mode = 1'b1;
    run_frame(mat_a, 4, -1, 1'b0, 1'b1, 1'b0);
    tr_mode = 1'b0;
    repeat (2) @(posedge aclk);

    // source starvation after two vectors
    for (int i = 0; i < 4; i++) vecs[i] = 64'hCAFE_0000_0000_0000 + 64'(i);
    run_frame(mat_b, 4, 2, 1'b0, 1'b1, 1'b0);

    // start while busy, then a back-to-back frame
    vecs[0] = 64'h1111; vecs[1] = 64'h2222; vecs[2] = 64'h3333;
    run_frame(mat_a, 3, -1, 1'b1, 1'b0, 1'b1);
    run_frame(mat_b, 3, -1, 1'b0, 1'b1, 1'b1);

    // reset mid-frame
    clear_mon();
    for (int i = 0; i < 4; i++) vecs[i] = 64'h7700 + 64'(i);
    fork drive_src(4, -1); join_none
    @(posedge aclk); #1;
    cfg_mat = mat_a; cfg_len = LW'(4); start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    t = 0;
    while (rx_d.size() < 4 && t < 50) begin
      @(negedge aclk); #1;
      t++;
    end
    chk("reached_vec", 64'(rx_d.size() >= 4), 64'd1);
    @(posedge aclk); #1;
    aresetn = 1'b0; src_abort = 1'b1;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    check_zero("midrst");
    n0 = rx_d.size();
    repeat (6) @(posedge aclk);
    #1;
    chk("rst_no_beats", 64'(rx_d.size()), 64'(n0));
    chk("rst_no_done", 64'(done_q.size()), 64'd0);
    src_abort = 1'b0;

    // fresh frame after reset
    for (int i = 0; i < 2; i++) vecs[i] = 64'h9900 + 64'(i);
    run_frame(mat_b, 2, -1, 1'b0, 1'b1, 1'b1);

    // maximum length for a 4-bit counter: 15 vectors
    for (int i = 0; i < 15; i++) vecs[i] = 64'h0123_0000_0000_0000 + 64'(i * 17);
    run_frame(mat_a, 15, -1, 1'b0, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
